// File: rtl/sim_video_out.sv
// Video output stage: pixel-to-RGB conversion (mono or palette), one-ce_pix output
// pipeline for colour and timing, and line/frame measurement of the incoming raster.
module sim_video_out #(
    parameter int          BPP      = 1,
    parameter int          MODE     = 0,
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce_pix,
    input  logic [BPP-1:0]  pix,
    input  logic            hblank,
    input  logic            vblank,
    input  logic            hsync,
    input  logic            vsync,
    input  logic            pal_we,
    input  logic [BPP-1:0]  pal_addr,
    input  logic [23:0]     pal_data,
    output logic [7:0]      VGA_R,
    output logic [7:0]      VGA_G,
    output logic [7:0]      VGA_B,
    output logic            VGA_HS,
    output logic            VGA_VS,
    output logic            VGA_HB,
    output logic            VGA_VB,
    output logic [15:0]     frame_cnt,
    output logic [11:0]     line_width,
    output logic [11:0]     frame_height,
    output logic            meas_valid
);

    localparam int          NPAL    = 1 << BPP;
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    logic [23:0] pal_q [NPAL];
    logic [23:0] pal_d [NPAL];
    logic [23:0] color;
    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d;
    logic        hb_prev_q, hb_prev_d, vb_prev_q, vb_prev_d;
    logic        vb_seen_q, vb_seen_d, meas_valid_q, meas_valid_d;
    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [11:0] line_width_q, line_width_d, frame_height_q, frame_height_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [11:0] v_next;
    logic        hb_rise, vb_rise;

    always_comb begin
        for (int i = 0; i < NPAL; i++) pal_d[i] = pal_q[i];
        if (MODE == 1 && pal_we) pal_d[pal_addr] = pal_data;
    end

    // Lookup reads pal_q, so a same-cycle write to the entry shows up one ce_pix later.
    always_comb begin
        color = 24'h000000;
        if (!(hblank || vblank)) begin
            if (MODE == 0) color = (pix != '0) ? FG_COLOR : BG_COLOR;
            else           color = pal_q[pix];
        end
    end

    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        hb_d  = hb_q;
        vb_d  = vb_q;
        if (ce_pix) begin
            rgb_d = color;
            hs_d  = hsync;
            vs_d  = vsync;
            hb_d  = hblank;
            vb_d  = vblank;
        end
    end

    assign hb_rise = hblank & ~hb_prev_q;
    assign vb_rise = vblank & ~vb_prev_q;

    // A vblank rising together with hblank still counts the line just finished.
    always_comb begin
        hb_prev_d      = hb_prev_q;
        vb_prev_d      = vb_prev_q;
        h_cnt_d        = h_cnt_q;
        v_cnt_d        = v_cnt_q;
        line_width_d   = line_width_q;
        frame_height_d = frame_height_q;
        frame_cnt_d    = frame_cnt_q;
        vb_seen_d      = vb_seen_q;
        meas_valid_d   = meas_valid_q;
        v_next         = v_cnt_q;
        if (ce_pix) begin
            hb_prev_d = hblank;
            vb_prev_d = vblank;
            if (hb_rise) begin
                line_width_d = h_cnt_q;
                h_cnt_d      = 12'd0;
                if ((!vblank || vb_rise) && h_cnt_q != 12'd0 && v_cnt_q != CNT_MAX)
                    v_next = v_cnt_q + 12'd1;
            end else if (!hblank && !vblank && h_cnt_q != CNT_MAX) begin
                h_cnt_d = h_cnt_q + 12'd1;
            end
            v_cnt_d = v_next;
            if (vb_rise) begin
                frame_height_d = v_next;
                v_cnt_d        = 12'd0;
                frame_cnt_d    = frame_cnt_q + 16'd1;
                vb_seen_d      = 1'b1;
                if (vb_seen_q) meas_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPAL; i++) pal_q[i] <= (i == 0) ? BG_COLOR : FG_COLOR;
            rgb_q          <= 24'h000000;
            hs_q           <= 1'b0;
            vs_q           <= 1'b0;
            hb_q           <= 1'b1;
            vb_q           <= 1'b1;
            hb_prev_q      <= 1'b1;
            vb_prev_q      <= 1'b1;
            h_cnt_q        <= 12'd0;
            v_cnt_q        <= 12'd0;
            line_width_q   <= 12'd0;
            frame_height_q <= 12'd0;
            frame_cnt_q    <= 16'd0;
            vb_seen_q      <= 1'b0;
            meas_valid_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NPAL; i++) pal_q[i] <= pal_d[i];
            rgb_q          <= rgb_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            hb_q           <= hb_d;
            vb_q           <= vb_d;
            hb_prev_q      <= hb_prev_d;
            vb_prev_q      <= vb_prev_d;
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            line_width_q   <= line_width_d;
            frame_height_q <= frame_height_d;
            frame_cnt_q    <= frame_cnt_d;
            vb_seen_q      <= vb_seen_d;
            meas_valid_q   <= meas_valid_d;
        end
    end

    assign VGA_R        = rgb_q[23:16];
    assign VGA_G        = rgb_q[15:8];
    assign VGA_B        = rgb_q[7:0];
    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_HB       = hb_q;
    assign VGA_VB       = vb_q;
    assign frame_cnt    = frame_cnt_q;
    assign line_width   = line_width_q;
    assign frame_height = frame_height_q;
    assign meas_valid   = meas_valid_q;

endmodule
